// File: rtl/fma_align_sum_pipe.sv
// FMA addend alignment and signed-magnitude add in a two-stage valid/ready pipeline.
// Define FMA_ALIGN_STICKY_EN to track shifted-out bits in sticky; otherwise sticky is 0.
module fma_align_sum_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int GUARD = 3,
  localparam int SW = 2*MAN_W + GUARD + 3,
  localparam int EW = EXP_W + 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ps,
  input  logic               zs,
  input  logic [EW-1:0]      pe,
  input  logic [EXP_W-1:0]   ze,
  input  logic [2*MAN_W+1:0] pm,
  input  logic [MAN_W-1:0]   zm,
  input  logic               p_zero,
  input  logic               z_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      sm,
  output logic [EW-1:0]      se,
  output logic               ms,
  output logic               sticky
);

  logic          s1_valid;
  logic          s2_ready;
  logic [SW-1:0] s1_p;
  logic [SW-1:0] s1_z;
  logic [EW-1:0] s1_se;
  logic          s1_ps;
  logic          s1_zs;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;

  // Exponent compare: a zero operand still takes part, except when both are zero.
  logic signed [EW-1:0] pe_s;
  logic signed [EW-1:0] ze_s;
  logic signed [EW-1:0] se_s;
  logic [EW:0]          p_sh;
  logic [EW:0]          z_sh;
  logic [SW-1:0]        p_vec;
  logic [SW-1:0]        z_vec;

  assign pe_s = pe;
  assign ze_s = (ze == '0) ? EW'(1) : EW'(ze);
  assign se_s = ((p_zero & z_zero) || (pe_s >= ze_s)) ? pe_s : ze_s;
  // A negative z_sh only occurs when z is zero, where it saturates harmlessly.
  assign p_sh = {se_s[EW-1], se_s} - {pe_s[EW-1], pe_s};
  assign z_sh = {se_s[EW-1], se_s} - {ze_s[EW-1], ze_s};

  assign p_vec = p_zero ? '0 : {1'b0, pm, {GUARD{1'b0}}};
  assign z_vec = z_zero ? '0 : {2'b00, (ze != '0), zm, {(MAN_W+GUARD){1'b0}}};

  function automatic logic [SW-1:0] align(input logic [SW-1:0] v, input logic [EW:0] sh);
    align = (int'(sh) >= SW) ? '0 : v >> sh;
  endfunction

  // NOTE: payload registers carry no reset; s1_valid qualifies them, so reset-time contents never matter.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_p  <= align(p_vec, p_sh);
      s1_z  <= align(z_vec, z_sh);
      s1_se <= se_s;
      s1_ps <= ps;
      s1_zs <= zs;
    end
  end

  logic [SW-1:0] sum_nxt;
  logic          ms_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_nxt = s1_p + s1_z;
    ms_nxt  = s1_ps;
    if (s1_ps != s1_zs) begin
      if (s1_p > s1_z) begin
        sum_nxt = s1_p - s1_z;
        ms_nxt  = s1_ps;
      end else if (s1_z > s1_p) begin
        sum_nxt = s1_z - s1_p;
        ms_nxt  = s1_zs;
      end else begin
        sum_nxt = '0;
        ms_nxt  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sm        <= '0;
      se        <= '0;
      ms        <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sm <= sum_nxt;
          se <= s1_se;
          ms <= ms_nxt;
        end
      end
    end
  end

`ifdef FMA_ALIGN_STICKY_EN
  function automatic logic lost_bits(input logic [SW-1:0] v, input logic [EW:0] sh);
    lost_bits = (int'(sh) >= SW) ? |v : |(v & ~({SW{1'b1}} << sh));
  endfunction

  logic s1_sticky;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) s1_sticky <= lost_bits(p_vec, p_sh) | lost_bits(z_vec, z_sh);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky <= 1'b0;
    else if (s2_ready && s1_valid) sticky <= s1_sticky;
  end
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fma_align_sum_pipe.sv
// Scoreboard bench for fma_align_sum_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized operands against an arithmetic reference model.
module tb_fma_align_sum_pipe;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int GUARD = 3;
  localparam int SW    = 2*MAN_W + GUARD + 3;
  localparam int EW    = EXP_W + 2;
  localparam int PW    = 2*MAN_W + 2;
  localparam int ZMAX  = (1 << EXP_W) - 1;
  localparam int NRAND = 300;
`ifdef FMA_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic             ps;
    logic             zs;
    logic [EW-1:0]    pe;
    logic [EXP_W-1:0] ze;
    logic [PW-1:0]    pm;
    logic [MAN_W-1:0] zm;
    logic             p_zero;
    logic             z_zero;
  } op_t;

  typedef struct packed {
    logic [SW-1:0] sm;
    logic [EW-1:0] se;
    logic          ms;
    logic          sticky;
  } res_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             ps;
  logic             zs;
  logic [EW-1:0]    pe;
  logic [EXP_W-1:0] ze;
  logic [PW-1:0]    pm;
  logic [MAN_W-1:0] zm;
  logic             p_zero;
  logic             z_zero;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    sm;
  logic [EW-1:0]    se;
  logic             ms;
  logic             sticky;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  res_t sb[$];

  fma_align_sum_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GUARD(GUARD)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ps(ps), .zs(zs), .pe(pe), .ze(ze), .pm(pm), .zm(zm),
    .p_zero(p_zero), .z_zero(z_zero), .out_valid(out_valid), .out_ready(out_ready),
    .sm(sm), .se(se), .ms(ms), .sticky(sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: values in units of the lowest guard bit, shifted by division.
  function automatic void trunc(input longint v, input int sh, output longint a, output bit lost);
    if (v == 0) begin
      a = 0; lost = 1'b0;
    end else if (sh >= 48) begin
      a = 0; lost = 1'b1;
    end else begin
      a = v / (longint'(1) << sh);
      lost = (a * (longint'(1) << sh)) != v;
    end
  endfunction

  function automatic res_t model(input op_t o);
    res_t   r;
    int     pe_i, ze_eff, se_i;
    longint pv, zv, pa, za, tot;
    bit     lp, lz;
    pe_i   = int'($signed(o.pe));
    ze_eff = (o.ze == 0) ? 1 : int'(o.ze);
    pv = o.p_zero ? 0 : longint'(o.pm) * (longint'(1) << GUARD);
    zv = o.z_zero ? 0 : longint'({(o.ze != 0), o.zm}) * (longint'(1) << (MAN_W + GUARD));
    if (o.p_zero && o.z_zero) se_i = pe_i;
    else se_i = (pe_i > ze_eff) ? pe_i : ze_eff;
    trunc(pv, se_i - pe_i, pa, lp);
    trunc(zv, se_i - ze_eff, za, lz);
    tot = (o.ps ? -pa : pa) + (o.zs ? -za : za);
    r.sm = SW'((tot < 0) ? -tot : tot);
    if (tot < 0) r.ms = 1'b1;
    else if (tot > 0) r.ms = 1'b0;
    else r.ms = (o.ps == o.zs) ? o.ps : 1'b0;
    r.se = EW'(se_i);
    r.sticky = STK & (lp | lz);
    return r;
  endfunction

  function automatic op_t mk_op(input bit ps_i, input bit zs_i, input int pe_i, input int ze_i,
                                input logic [PW-1:0] pm_i, input logic [MAN_W-1:0] zm_i,
                                input bit pz_i, input bit zz_i);
    op_t o;
    o.ps = ps_i; o.zs = zs_i; o.pe = EW'(pe_i); o.ze = EXP_W'(ze_i);
    o.pm = pm_i; o.zm = zm_i; o.p_zero = pz_i; o.z_zero = zz_i;
    return o;
  endfunction

  function automatic res_t mk_res(input logic [SW-1:0] sm_i, input int se_i, input bit ms_i, input bit st_i);
    res_t r;
    r.sm = sm_i; r.se = EW'(se_i); r.ms = ms_i; r.sticky = st_i;
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  pe_i, ze_i;
    pe_i = int'($urandom_range(0, 50)) - 10;
    if ($urandom_range(0, 2) == 0) begin
      ze_i = pe_i + int'($urandom_range(0, 4)) - 2;
      if (ze_i < 0) ze_i = 0;
      if (ze_i > ZMAX) ze_i = ZMAX;
    end else begin
      ze_i = int'($urandom_range(0, ZMAX));
    end
    o.ps = 1'($urandom_range(0, 1));
    o.zs = 1'($urandom_range(0, 1));
    o.zm = MAN_W'($urandom);
    o.pm = PW'($urandom);
    if ($urandom_range(0, 1) == 0) o.pm[PW-1:PW-2] = 2'b01;
    if ($urandom_range(0, 7) == 0) begin
      ze_i = (pe_i < 1) ? 1 : ((pe_i > ZMAX) ? ZMAX : pe_i);
      pe_i = ze_i;
      o.pm = {2'b01, o.zm, {MAN_W{1'b0}}};
    end
    o.p_zero = ($urandom_range(0, 7) == 0);
    o.z_zero = ($urandom_range(0, 7) == 0);
    if (o.z_zero) begin
      ze_i = 0;
      o.zm = '0;
      if (pe_i < 1) pe_i = 1;
    end
    o.pe = EW'(pe_i);
    o.ze = EXP_W'(ze_i);
    return o;
  endfunction

  task automatic drive(input op_t o);
    ps = o.ps; zs = o.zs; pe = o.pe; ze = o.ze;
    pm = o.pm; zm = o.zm; p_zero = o.p_zero; z_zero = o.z_zero;
  endtask

  // Called at posedge+1; returns at the posedge+1 following acceptance.
  task automatic send(input op_t o, input res_t e);
    int waited = 0;
    drive(o);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  res_t                mon_e;
  bit                  holding = 1'b0;
  logic [SW+EW+1:0]    held;

  always @(negedge clk) begin
    if (!reset_n) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {sm, se, ms, sticky}, held);
      end
      if (out_valid && out_ready) begin
        n_out++;
        check("out_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sm", sm, mon_e.sm);
          check("se", se, mon_e.se);
          check("ms", ms, mon_e.ms);
          check("sticky", sticky, mon_e.sticky);
        end
      end
      holding = out_valid && !out_ready;
      held    = {sm, se, ms, sticky};
    end
  end

  initial begin
    op_t              o;
    op_t              dir_op[11];
    res_t             dir_res[11];
    int               n0;
    logic [SW+EW+1:0] snap;
    bit               rand_done;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(mk_op(0, 0, 0, 0, '0, '0, 0, 0));
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sm", sm, 0);
    check("rst_se", se, 0);
    check("rst_ms", ms, 0);
    check("rst_sticky", sticky, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);

    dir_op[0]  = mk_op(0, 0, 15, 15, 22'h100000, 10'h000, 0, 0);
    dir_res[0] = mk_res(26'h1000000, 15, 0, 0);
    dir_op[1]  = mk_op(0, 1, 15, 15, 22'h100000, 10'h000, 0, 0);
    dir_res[1] = mk_res(26'h0000000, 15, 0, 0);
    dir_op[2]  = mk_op(0, 0, 30, 1, 22'h100000, 10'h000, 0, 0);
    dir_res[2] = mk_res(26'h0800000, 30, 0, STK);
    dir_op[3]  = mk_op(0, 1, 10, 15, 22'h155555, 10'h000, 1, 0);
    dir_res[3] = mk_res(26'h0800000, 15, 1, 0);
    dir_op[4]  = mk_op(1, 1, 0, 0, 22'h100000, 10'h200, 0, 0);
    dir_res[4] = mk_res(26'h0800000, 1, 1, 0);
    dir_op[5]  = mk_op(1, 1, -3, 0, 22'h000000, 10'h000, 1, 1);
    dir_res[5] = mk_res(26'h0000000, -3, 1, 0);
    dir_op[6]  = mk_op(0, 0, 38, 15, 22'h100000, 10'h000, 0, 0);
    dir_res[6] = mk_res(26'h0800001, 38, 0, 0);
    dir_op[7]  = mk_op(0, 0, 40, 15, 22'h100000, 10'h000, 0, 0);
    dir_res[7] = mk_res(26'h0800000, 40, 0, STK);
    dir_op[8]  = mk_op(0, 0, 41, 15, 22'h100000, 10'h000, 0, 0);
    dir_res[8] = mk_res(26'h0800000, 41, 0, STK);
    dir_op[9]  = mk_op(0, 1, 12, 15, 22'h180000, 10'h000, 0, 0);
    dir_res[9] = mk_res(26'h0680000, 15, 1, 0);
    dir_op[10]  = mk_op(0, 0, 15, 15, 22'h3FFFFF, 10'h3FF, 0, 0);
    dir_res[10] = mk_res(26'h2FFDFF8, 15, 0, 0);
    for (int i = 0; i < 11; i++) send(dir_op[i], dir_res[i]);
    wait_drain();

    out_ready = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          o = rand_op();
          send(o, model(o));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        snap = {sm, se, ms, sticky};
        @(posedge clk);
        #1;
        check("bp_hold", {sm, se, ms, sticky}, snap);
        check("bp_in_ready_still_low", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_out_count", n_out - n0, 4);

    out_ready = 1'b0;
    o = rand_op();
    send(o, model(o));
    o = rand_op();
    send(o, model(o));
    check("inflight_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sm", sm, 0);
    check("midrst_se", se, 0);
    check("midrst_ms", ms, 0);
    sb.delete();
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    o = rand_op();
    send(o, model(o));
    wait_drain();
    check("post_rst_out_count", n_out - n0, 1);

    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          o = rand_op();
          send(o, model(o));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
